// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU host-side bus master.
// Holds the state encoding, the default address map and the C-word count helper.
package tpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        MUL,
        WAIT,
        RD_REQ,
        RD_WAIT,
        RD_OUT
    } hostState_t;

    typedef enum logic [1:0] {
        REGION_A,
        REGION_B,
        REGION_C,
        REGION_CMD
    } region_t;

    localparam logic [15:0] DEF_A_BASE   = 16'h0100;
    localparam logic [15:0] DEF_B_BASE   = 16'h0200;
    localparam logic [15:0] DEF_C_BASE   = 16'h0300;
    localparam logic [15:0] DEF_CMD_ADDR = 16'h0400;

    // Every bus word occupies 8 bytes of address space.
    localparam int WORD_SHIFT = 3;

    function automatic int cWords(input int dim, input int bitsC, input int dataw);
        return (dim * bitsC) / dataw;
    endfunction

endpackage

// File: rtl/tpu_host_master_if.sv
// Memory-mapped bus between the host master and the TPU slave port.
interface tpu_host_master_if #(
    parameter int ADDRW = 16,
    parameter int DATAW = 64
);
    logic             bus_en;
    logic             bus_r_w;
    logic [ADDRW-1:0] bus_addr;
    logic [DATAW-1:0] bus_wdata;
    logic [DATAW-1:0] bus_rdata;

    modport master (
        output bus_en,
        output bus_r_w,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  bus_en,
        input  bus_r_w,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata
    );
endinterface

// File: rtl/tpu_addr_gen.sv
// Maps a region select plus word index onto a TPU byte address.
// Additions are ADDRW wide and wrap silently.
module tpu_addr_gen
    import tpu_pkg::*;
#(
    parameter int               ADDRW    = 16,
    parameter logic [ADDRW-1:0] A_BASE   = ADDRW'(DEF_A_BASE),
    parameter logic [ADDRW-1:0] B_BASE   = ADDRW'(DEF_B_BASE),
    parameter logic [ADDRW-1:0] C_BASE   = ADDRW'(DEF_C_BASE),
    parameter logic [ADDRW-1:0] CMD_ADDR = ADDRW'(DEF_CMD_ADDR)
) (
    input  region_t          region,
    input  logic [ADDRW-1:0] index,
    output logic [ADDRW-1:0] addr
);

    logic [ADDRW-1:0] offset;

    assign offset = index << WORD_SHIFT;

    always_comb begin
        addr = CMD_ADDR;
        case (region)
            REGION_A:   addr = A_BASE + offset;
            REGION_B:   addr = B_BASE + offset;
            REGION_C:   addr = C_BASE + offset;
            REGION_CMD: addr = CMD_ADDR;
            default:    addr = CMD_ADDR;
        endcase
    end

endmodule

// File: rtl/tpu_host_master.sv
// Host-side bus initiator for the TPU: loads A/B rows from a stream, triggers the
// multiply, waits out the compute time and streams every C word back to the host.
module tpu_host_master
    import tpu_pkg::*;
#(
    parameter int               DIM        = 8,
    parameter int               BITS_AB    = 8,
    parameter int               BITS_C     = 16,
    parameter int               ADDRW      = 16,
    parameter int               DATAW      = 64,
    parameter logic [ADDRW-1:0] A_BASE     = ADDRW'(DEF_A_BASE),
    parameter logic [ADDRW-1:0] B_BASE     = ADDRW'(DEF_B_BASE),
    parameter logic [ADDRW-1:0] C_BASE     = ADDRW'(DEF_C_BASE),
    parameter logic [ADDRW-1:0] CMD_ADDR   = ADDRW'(DEF_CMD_ADDR),
    parameter int               MUL_CYCLES = 22,
    parameter int               RD_LAT     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic [DATAW-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DATAW-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    tpu_host_master_if.master bus
);

    localparam int C_WORDS = cWords(DIM, BITS_C, DATAW);
    localparam int N_C     = DIM * C_WORDS;
    localparam int ROW_W   = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int K_W     = (N_C > 1) ? $clog2(N_C) : 1;
    localparam int WAIT_W  = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam int LAT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    if (DATAW != DIM * BITS_AB) begin : gCfgErr
        $error("tpu_host_master: DATAW must equal DIM*BITS_AB");
    end

    hostState_t       state;
    hostState_t       stateNext;
    logic [ROW_W-1:0] rowCnt;
    logic [K_W-1:0]   kCnt;
    logic [WAIT_W-1:0] waitCnt;
    logic [LAT_W-1:0] latCnt;

    logic             inBeat;
    logic             lastRow;
    logic             lastWord;
    logic             waitDone;
    logic             latDone;

    logic             busEn;
    logic             busRw;
    logic [DATAW-1:0] busWdata;
    region_t          region;
    logic [ADDRW-1:0] index;
    logic [ADDRW-1:0] genAddr;

    assign inBeat   = in_valid && in_ready;
    assign lastRow  = (rowCnt == ROW_W'(DIM - 1));
    assign lastWord = (kCnt == K_W'(N_C - 1));
    assign waitDone = (waitCnt == WAIT_W'(MUL_CYCLES - 1));
    assign latDone  = (latCnt == LAT_W'(RD_LAT - 1));

    // State register, counters and the C-word capture register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rowCnt   <= '0;
            kCnt     <= '0;
            waitCnt  <= '0;
            latCnt   <= '0;
            out_data <= '0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    rowCnt <= '0;
                    kCnt   <= '0;
                end
                LOAD_A, LOAD_B: begin
                    if (inBeat) rowCnt <= lastRow ? '0 : rowCnt + 1'b1;
                end
                MUL:     waitCnt <= '0;
                WAIT:    waitCnt <= waitCnt + 1'b1;
                RD_REQ:  latCnt  <= '0;
                RD_WAIT: begin
                    latCnt <= latCnt + 1'b1;
                    if (latDone) out_data <= bus.bus_rdata;
                end
                RD_OUT: begin
                    if (out_ready) kCnt <= lastWord ? '0 : kCnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = LOAD_A;
            LOAD_A:  if (inBeat && lastRow) stateNext = LOAD_B;
            LOAD_B:  if (inBeat && lastRow) stateNext = MUL;
            MUL:     stateNext = WAIT;
            WAIT:    if (waitDone) stateNext = RD_REQ;
            RD_REQ:  stateNext = RD_WAIT;
            RD_WAIT: if (latDone) stateNext = RD_OUT;
            RD_OUT:  if (out_ready) stateNext = lastWord ? IDLE : RD_REQ;
            default: stateNext = IDLE;
        endcase
    end

    // Writes during the load states follow the input handshake in the same cycle.
    always_comb begin
        busy      = (state != IDLE);
        done      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busEn     = 1'b0;
        busRw     = 1'b0;
        busWdata  = '0;
        region    = REGION_A;
        index     = '0;
        case (state)
            LOAD_A, LOAD_B: begin
                in_ready = 1'b1;
                busEn    = in_valid;
                busRw    = 1'b1;
                busWdata = in_data;
                region   = (state == LOAD_A) ? REGION_A : REGION_B;
                index    = ADDRW'(rowCnt);
            end
            MUL: begin
                busEn    = 1'b1;
                busRw    = 1'b1;
                busWdata = DATAW'(1);
                region   = REGION_CMD;
            end
            RD_REQ: begin
                busEn  = 1'b1;
                region = REGION_C;
                index  = ADDRW'(kCnt);
            end
            RD_OUT: begin
                out_valid = 1'b1;
                done      = out_ready && lastWord;
            end
            default: ;
        endcase
    end

    tpu_addr_gen #(
        .ADDRW   (ADDRW),
        .A_BASE  (A_BASE),
        .B_BASE  (B_BASE),
        .C_BASE  (C_BASE),
        .CMD_ADDR(CMD_ADDR)
    ) uAddrGen (
        .region(region),
        .index (index),
        .addr  (genAddr)
    );

    // Address, data and direction are forced low whenever no transaction is issued.
    assign bus.bus_en    = busEn;
    assign bus.bus_r_w   = busEn && busRw;
    assign bus.bus_addr  = busEn ? genAddr : '0;
    assign bus.bus_wdata = busEn ? busWdata : '0;

endmodule

// File: tb/tb_tpu_host_master.sv
// Directed bench for tpu_host_master: default instance u0 plus a short-latency
// instance u1 (MUL_CYCLES=5, RD_LAT=2), each backed by a simple TPU read model.
module tb_tpu_host_master;

    localparam int DIM = 8;
    localparam int NC  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        out_ready0 = 1'b0, out_ready1 = 1'b1;
    logic        busy0, done0, in_ready0, out_valid0;
    logic        busy1, done1, in_ready1, out_valid1;
    logic [63:0] out_data0, out_data1;

    always #5 clk = ~clk;

    tpu_host_master_if #(.ADDRW(16), .DATAW(64)) bif0 ();
    tpu_host_master_if #(.ADDRW(16), .DATAW(64)) bif1 ();

    tpu_host_master u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
        .bus(bif0)
    );

    tpu_host_master #(.MUL_CYCLES(5), .RD_LAT(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .bus(bif1)
    );

    function automatic logic [63:0] cModel(input logic [15:0] a);
        return {a, ~a, a ^ 16'h5A5A, a + 16'h1111};
    endfunction

    function automatic logic [63:0] rowPat(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {8{b}} ^ 64'hF0E1_D2C3_B4A5_9687;
    endfunction

    // TPU read models: one-cycle latency for u0, two-cycle for u1.
    logic [63:0] rdPipe1;
    always @(posedge clk) begin
        if (bif0.bus_en && !bif0.bus_r_w) bif0.bus_rdata <= cModel(bif0.bus_addr);
        if (bif1.bus_en && !bif1.bus_r_w) rdPipe1 <= cModel(bif1.bus_addr);
        bif1.bus_rdata <= rdPipe1;
    end

    typedef struct {
        int          c;
        logic        rw;
        logic [15:0] a;
        logic [63:0] d;
    } txn_t;

    txn_t        busQ[$];
    txn_t        outQ[$];
    int          rd1Q[$];
    int          ov1Q[$];
    logic [63:0] out1Q[$];
    int          cyc = 0, doneCnt = 0, doneCyc = -1, doneCnt1 = 0, enNoBeat = 0, trig1 = -1;
    logic        prevDone = 1'b0, busyAfterDone = 1'b1, prevOv1 = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (bif0.bus_en) busQ.push_back('{cyc, bif0.bus_r_w, bif0.bus_addr, bif0.bus_wdata});
        if (bif0.bus_en && bif0.bus_r_w && bif0.bus_addr != 16'h0400 && !(in_valid && in_ready0))
            enNoBeat++;
        if (out_valid0 && out_ready0) outQ.push_back('{cyc, 1'b0, 16'h0, out_data0});
        if (prevDone) busyAfterDone = busy0;
        prevDone = done0;
        if (done0) begin doneCnt++; doneCyc = cyc; end
        if (bif1.bus_en && bif1.bus_r_w && bif1.bus_addr == 16'h0400) trig1 = cyc;
        if (bif1.bus_en && !bif1.bus_r_w) rd1Q.push_back(cyc);
        if (out_valid1 && !prevOv1) ov1Q.push_back(cyc);
        prevOv1 = out_valid1;
        if (out_valid1 && out_ready1) out1Q.push_back(out_data1);
        if (done1) doneCnt1++;
    end

    int cmpCnt = 0, errCnt = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        cmpCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic startJob(input bit sel);
        @(posedge clk); #1;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic feed(input bit sel, input bit stall);
        int   i = 0, g = 0;
        bit   ph = 1'b0;
        logic hs;
        while (i < 2 * DIM && g < 200) begin
            in_data  = rowPat(i);
            in_valid = stall ? !ph : 1'b1;
            @(negedge clk);
            hs = in_valid && (sel ? in_ready1 : in_ready0);
            @(posedge clk); #1;
            if (hs) i++;
            ph = !ph;
            g++;
        end
        in_valid = 1'b0;
        if (i != 2 * DIM) checkVal("feedTimeout", 64'(i), 64'(2 * DIM));
    endtask

    task automatic waitDone(input int prev);
        int g = 0;
        while (doneCnt == prev && g < 400) begin @(posedge clk); g++; end
        #1;
        if (doneCnt == prev) checkVal("doneTimeout", 64'(doneCnt), 64'(prev + 1));
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic int rdCyc(input int k);
        int r = 0;
        foreach (busQ[j]) if (!busQ[j].rw) begin
            if (r == k) return busQ[j].c;
            r++;
        end
        return -1;
    endfunction

    function automatic int nWrites();
        int w = 0;
        foreach (busQ[j]) if (busQ[j].rw) w++;
        return w;
    endfunction

    task automatic checkTraffic(input string t, output int trigC, output int firstW, output int firstR);
        int w = 0, r = 0;
        trigC = -1; firstW = -1; firstR = -1;
        foreach (busQ[j]) begin
            if (busQ[j].rw) begin
                if (firstW < 0) firstW = busQ[j].c;
                if (w < 2 * DIM) begin
                    checkVal({t, ".wrAddr"}, 64'(busQ[j].a),
                             64'(16'(w < DIM ? 16'h0100 + 8 * w : 16'h0200 + 8 * (w - DIM))));
                    checkVal({t, ".wrData"}, busQ[j].d, rowPat(w));
                end else begin
                    checkVal({t, ".cmdAddr"}, 64'(busQ[j].a), 64'h0400);
                    checkVal({t, ".cmdData"}, busQ[j].d, 64'd1);
                    trigC = busQ[j].c;
                end
                w++;
            end else begin
                if (firstR < 0) firstR = busQ[j].c;
                checkVal({t, ".rdAddr"}, 64'(busQ[j].a), 64'(16'(16'h0300 + 8 * r)));
                r++;
            end
        end
        checkVal({t, ".wrCount"}, 64'(w), 64'(2 * DIM + 1));
        checkVal({t, ".rdCount"}, 64'(r), 64'(NC));
        foreach (outQ[j]) checkVal({t, ".outData"}, outQ[j].d, cModel(16'(16'h0300 + 8 * j)));
        checkVal({t, ".outCount"}, 64'(outQ.size()), 64'(NC));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   trigC, firstW, firstR, g, sz, dc;
        logic [63:0] held;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst.busy", busy0, 1'b0);
        checkVal("rst.done", done0, 1'b0);
        checkVal("rst.inReady", in_ready0, 1'b0);
        checkVal("rst.outValid", out_valid0, 1'b0);
        checkVal("rst.busEn", bif0.bus_en, 1'b0);
        checkVal("rst.busAddr", bif0.bus_addr, 16'h0);
        checkVal("rst.outData", out_data0, 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full job, source and sink always ready.
        out_ready0 = 1'b1;
        busQ.delete(); outQ.delete();
        startJob(1'b0);
        feed(1'b0, 1'b0);
        waitDone(0);
        checkTraffic("full", trigC, firstW, firstR);
        checkVal("full.trigToRead", 64'(firstR - trigC), 64'd23);
        checkVal("full.latency", 64'(doneCyc - firstW), 64'd86);
        checkVal("full.doneOnce", 64'(doneCnt), 64'd1);
        checkVal("full.busyAfterDone", busyAfterDone, 1'b0);

        // Stalled input plus ignored start pulses in LOAD_B and WAIT.
        busQ.delete(); outQ.delete();
        startJob(1'b0);
        fork
            feed(1'b0, 1'b1);
            begin
                g = 0;
                while (nWrites() < 10 && g < 200) begin @(posedge clk); g++; end
                #1; start0 = 1'b1; @(posedge clk); #1; start0 = 1'b0;
                g = 0;
                while (nWrites() < 17 && g < 200) begin @(posedge clk); g++; end
                repeat (3) @(posedge clk);
                #1; start0 = 1'b1; @(posedge clk); #1; start0 = 1'b0;
            end
        join
        waitDone(1);
        repeat (10) @(posedge clk);
        #1;
        checkTraffic("stall", trigC, firstW, firstR);
        checkVal("stall.enNoBeat", 64'(enNoBeat), 64'd0);
        checkVal("stall.doneOnce", 64'(doneCnt), 64'd2);
        checkVal("stall.noRequeue", busy0, 1'b0);
        checkVal("stall.noExtraTxn", 64'(busQ.size()), 64'd33);

        // Output backpressure on word 3.
        busQ.delete(); outQ.delete();
        startJob(1'b0);
        fork
            feed(1'b0, 1'b0);
            begin
                g = 0;
                while (outQ.size() < 3 && g < 300) begin @(posedge clk); g++; end
                #1; out_ready0 = 1'b0;
                g = 0;
                do begin @(negedge clk); g++; end while (!out_valid0 && g < 20);
                held = out_data0;
                checkVal("bp.word3", held, cModel(16'h0318));
                for (int s = 0; s < 5; s++) begin
                    if (s > 0) @(negedge clk);
                    checkVal("bp.valid", out_valid0, 1'b1);
                    checkVal("bp.stable", out_data0, held);
                    checkVal("bp.noBusEn", bif0.bus_en, 1'b0);
                end
                @(posedge clk); #1; out_ready0 = 1'b1;
            end
        join
        waitDone(2);
        checkTraffic("bp", trigC, firstW, firstR);
        checkVal("bp.word4AfterHs", 64'(rdCyc(4)), 64'(outQ[3].c + 1));

        // Reset while word 7 waits in RD_OUT, then a clean restart.
        busQ.delete(); outQ.delete();
        dc = doneCnt;
        startJob(1'b0);
        fork
            feed(1'b0, 1'b0);
            begin
                g = 0;
                while (outQ.size() < 7 && g < 300) begin @(posedge clk); g++; end
                #1; out_ready0 = 1'b0;
                g = 0;
                do begin @(negedge clk); g++; end while (!out_valid0 && g < 20);
                #2; rst_n = 1'b0;
                #1;
                checkVal("rstMid.outValid", out_valid0, 1'b0);
                checkVal("rstMid.busy", busy0, 1'b0);
                checkVal("rstMid.done", done0, 1'b0);
                checkVal("rstMid.busEn", bif0.bus_en, 1'b0);
                checkVal("rstMid.outData", out_data0, 64'h0);
                checkVal("rstMid.inReady", in_ready0, 1'b0);
            end
        join
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1; out_ready0 = 1'b1;
        sz = busQ.size();
        repeat (5) @(posedge clk);
        #1;
        checkVal("rstMid.noBusAfter", 64'(busQ.size()), 64'(sz));
        checkVal("rstMid.noDone", 64'(doneCnt), 64'(dc));
        busQ.delete(); outQ.delete();
        startJob(1'b0);
        feed(1'b0, 1'b0);
        waitDone(dc);
        checkTraffic("restart", trigC, firstW, firstR);
        checkVal("restart.firstAddr", 64'(busQ[0].a), 64'h0100);

        // Short compute time and two-cycle read latency.
        startJob(1'b1);
        feed(1'b1, 1'b0);
        g = 0;
        while (doneCnt1 == 0 && g < 400) begin @(posedge clk); g++; end
        repeat (2) @(posedge clk);
        #1;
        checkVal("fast.done", 64'(doneCnt1), 64'd1);
        checkVal("fast.busy", busy1, 1'b0);
        checkVal("fast.rdCount", 64'(rd1Q.size()), 64'(NC));
        if (rd1Q.size() == NC && ov1Q.size() == NC && out1Q.size() == NC) begin
            checkVal("fast.trigToRead", 64'(rd1Q[0] - trig1), 64'd6);
            for (int k = 0; k < NC; k++) begin
                checkVal("fast.reqToValid", 64'(ov1Q[k] - rd1Q[k]), 64'd3);
                checkVal("fast.outData", out1Q[k], cModel(16'(16'h0300 + 8 * k)));
            end
        end else begin
            checkVal("fast.outCount", 64'(out1Q.size()), 64'(NC));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
        $finish;
    end

endmodule
